// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: per-cycle PC / pipeline-latch load, hold and
// bubble decisions, halt drain sequencing and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             idex_dREN,
    input  logic [4:0]       idex_rt,
    input  logic             ex_redirect,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             exmem_halt,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MEMWAIT = 2'd1,
        S_DRAIN   = 2'd2,
        S_HALTED  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q;
    logic              halt_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic dwait;
    logic loaduse;
    logic stall_inc;
    logic flush_inc;

    assign dwait   = (exmem_dREN | exmem_dWEN) & ~dhit;
    assign loaduse = idex_dREN & (idex_rt != 5'd0) &
                     ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

    // Priority decision table; the first matching hazard owns the cycle.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a latch.
        pc_en       = 1'b1;
        pc_redirect = 1'b0;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (RST) begin
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else begin
            unique case (state_q)
                S_RUN, S_MEMWAIT: begin
                    if (dwait) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_en    = 1'b0;
                        memwb_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end else if (exmem_halt) begin
                        // Halt stall is the start of the drain, not a hazard stall.
                        pc_en       = 1'b0;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (ex_redirect) begin
                        pc_redirect = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (loaduse) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (!ihit) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end
                end
                S_DRAIN: begin
                    pc_en       = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    memwb_flush = 1'b1;
                end
                S_HALTED: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (flush_inc && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_RUN;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            unique case (state_q)
                S_RUN, S_MEMWAIT: begin
                    if (dwait)           state_q <= S_MEMWAIT;
                    else if (exmem_halt) state_q <= S_DRAIN;
                    else                 state_q <= S_RUN;
                end
                S_DRAIN: begin
                    state_q <= S_HALTED;
                    halt_q  <= 1'b1;
                end
                S_HALTED: state_q <= S_HALTED;
                default:  state_q <= S_RUN;
            endcase
        end
    end

    assign halt      = halt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state     = state_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage core. Each cycle it decides whether the PC and each pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) loads, holds or loads a bubble. Inputs are the cache handshakes (ihit/dhit), load-use hazards, EX-stage control-transfer redirects and halt retirement. It also owns the halt drain sequence and two saturating performance counters.

## Interface
- CNT_W, 16, width of stall_cnt and flush_cnt
- CLK  in  1  core clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access in MEM completes this cycle
- ifid_rs  in  5  rs field of instruction in IF/ID
- ifid_rt  in  5  rt field of instruction in IF/ID
- idex_dREN  in  1  instruction in ID/EX is a load
- idex_rt  in  5  destination rt of instruction in ID/EX
- ex_redirect  in  1  EX resolved taken beq/bne, j, jal or jr
- exmem_dREN, exmem_dWEN  in  1 each  memory request held in EX/MEM
- exmem_halt  in  1  halt instruction is in EX/MEM
- pc_en  out  1  PC loads next value
- pc_redirect  out  1  PC next value is EX target (valid only with pc_en)
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch loads
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch loads zeros instead of its inputs (meaningful only with matching _en=1)
- halt  out  1  core halted, sticky until RST
- stall_cnt  out  CNT_W  cycles with PC held (RUN/MEMWAIT only)
- flush_cnt  out  CNT_W  redirects taken
- state  out  2  RUN=0, MEMWAIT=1, DRAIN=2, HALTED=3

## Operation
- Registered state: 2-bit FSM, halt, stall_cnt, flush_cnt. All latch and PC controls are combinational from the state and inputs.
- dwait = (exmem_dREN | exmem_dWEN) & !dhit.
- loaduse = idex_dREN & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt).
- Default: all _en=1, all _flush=0, pc_en=1, pc_redirect=0.
- Decision priority in RUN/MEMWAIT (first match wins):
  1. dwait: pc_en=0; ifid/idex/exmem _en=0; memwb_en=1, memwb_flush=1.
  2. exmem_halt: pc_en=0; ifid/idex/exmem _flush=1; memwb loads the halt normally.
  3. ex_redirect: pc_redirect=1; ifid_flush=1, idex_flush=1; flush_cnt++. This overrides a pending fetch miss.
  4. loaduse: pc_en=0, ifid_en=0; idex_flush=1.
  5. !ihit: pc_en=0; ifid_flush=1.
- A redirect is never taken while dwait=1. The branch stays frozen in ID/EX and redirects on the first cycle dwait drops.
- DRAIN: pc_en=0; all four latches _en=1, _flush=1; counters frozen.
- HALTED: every _en=0, pc_en=0, all _flush=0; halt=1; counters frozen.
- While RST=1: pc_en=0; all latches _en=1, _flush=1. Next state RUN, halt=0, counters=0.
- FSM transitions:
  - RUN→MEMWAIT on dwait; MEMWAIT→RUN on !dwait. Both apply the same-cycle decision table.
  - RUN/MEMWAIT→DRAIN on exmem_halt & !dwait.
  - DRAIN→HALTED unconditionally.
  - HALTED holds until RST.
- stall_cnt increments on every RUN/MEMWAIT cycle with pc_en=0, excluding case 2.
- Both counters saturate at all-ones and do not wrap.

## Timing
- Zero-cycle decision latency: controls reflect the inputs in the same cycle. State and counters update at the next CLK edge.
- Load-use bubble is exactly one cycle, because ID/EX holds a bubble on the following cycle so loaduse drops.
- Redirect costs two bubbles (IF/ID and ID/EX). PC takes the target at the redirect edge.
- Halt sequence: exmem_halt high in cycle N → state=DRAIN in N+1 → state=HALTED and halt=1 in N+2.
- Simultaneous dwait and loaduse/redirect/!ihit: dwait wins, so nothing advances except the MEM/WB bubble.
- RST asserted in any state, including DRAIN or mid-dwait, takes effect at the next edge: state=RUN, halt=0, counters=0.

## Test plan
- Load-use: lw $2 then add $3,$2,$4 back to back, ihit=1 → exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Repeat with idex_rt=0 → no stall.
- Data wait: sw in EX/MEM, dhit low 3 cycles → state=MEMWAIT for 3 cycles; ifid/idex/exmem _en=0 and memwb_flush=1 in each; stall_cnt=3. On the 4th cycle dhit=1 → all advance, state=RUN.
- Redirect during data wait: beq taken in ID/EX while dwait holds 2 cycles → pc_redirect=0 in both cycles. Redirect on the cycle dhit=1: ifid_flush=idex_flush=1, flush_cnt=1.
- Fetch miss plus redirect: ihit=0 and ex_redirect=1 in the same cycle → pc_en=1, pc_redirect=1, ifid_flush=1, idex_flush=1.
- Halt: exmem_halt at cycle 10 → state=DRAIN at 11 with all flushes set; halt=1 and every _en=0 from 12 onward. Counters unchanged after 10.
- Reset and saturation: drive RST=1 in HALTED → halt=0, state=RUN, counters=0 next cycle. With CNT_W=4, hold ihit=0 for 20 cycles → stall_cnt stays at 15 with no wrap.
